// File: rtl/w0rm_mem_port_arbiter.sv
// Round-robin arbiter between instruction fetch (m0) and load/store (m1) in front of a
// single-port memory, one outstanding transaction. Optional timeout: W0RM_MEMARB_TIMEOUT_EN.
module w0rm_mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  mem_clk,
    input  logic                  mem_reset_n,
    input  logic                  m0_valid_i,
    input  logic                  m0_read_i,
    input  logic                  m0_write_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic                  m0_ready_o,
    output logic                  m0_valid_o,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_error_o,
    input  logic                  m1_valid_i,
    input  logic                  m1_read_i,
    input  logic                  m1_write_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic                  m1_ready_o,
    output logic                  m1_valid_o,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_error_o,
    output logic                  s_valid_o,
    output logic                  s_read_o,
    output logic                  s_write_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state, state_nxt;
    logic                  last_grant, last_grant_nxt;
    logic                  owner, owner_nxt;
    logic                  pick;
    logic                  rsp_fire, rsp_err;
    logic                  s_valid_nxt, s_read_nxt, s_write_nxt;
    logic [ADDR_WIDTH-1:0] s_addr_nxt;
    logic [DATA_WIDTH-1:0] s_data_nxt;
    logic                  m0_ready_nxt, m0_valid_nxt, m0_error_nxt;
    logic                  m1_ready_nxt, m1_valid_nxt, m1_error_nxt;
    logic [DATA_WIDTH-1:0] m0_data_nxt, m1_data_nxt;

`ifdef W0RM_MEMARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt, cnt_nxt;
`endif

    always_ff @(posedge mem_clk) begin
        if (!mem_reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            s_valid_o  <= 1'b0;
            s_read_o   <= 1'b0;
            s_write_o  <= 1'b0;
            s_addr_o   <= '0;
            s_data_o   <= '0;
            m0_ready_o <= 1'b0;
            m0_valid_o <= 1'b0;
            m0_error_o <= 1'b0;
            m0_data_o  <= '0;
            m1_ready_o <= 1'b0;
            m1_valid_o <= 1'b0;
            m1_error_o <= 1'b0;
            m1_data_o  <= '0;
`ifdef W0RM_MEMARB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            owner      <= owner_nxt;
            s_valid_o  <= s_valid_nxt;
            s_read_o   <= s_read_nxt;
            s_write_o  <= s_write_nxt;
            s_addr_o   <= s_addr_nxt;
            s_data_o   <= s_data_nxt;
            m0_ready_o <= m0_ready_nxt;
            m0_valid_o <= m0_valid_nxt;
            m0_error_o <= m0_error_nxt;
            m0_data_o  <= m0_data_nxt;
            m1_ready_o <= m1_ready_nxt;
            m1_valid_o <= m1_valid_nxt;
            m1_error_o <= m1_error_nxt;
            m1_data_o  <= m1_data_nxt;
`ifdef W0RM_MEMARB_TIMEOUT_EN
            cnt        <= cnt_nxt;
`endif
        end
    end

    // Pulses default low every cycle; address/data registers hold until overwritten.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        pick           = 1'b0;
        rsp_fire       = 1'b0;
        rsp_err        = 1'b0;
        s_valid_nxt    = 1'b0;
        s_read_nxt     = 1'b0;
        s_write_nxt    = 1'b0;
        s_addr_nxt     = s_addr_o;
        s_data_nxt     = s_data_o;
        m0_ready_nxt   = 1'b0;
        m0_valid_nxt   = 1'b0;
        m0_error_nxt   = 1'b0;
        m0_data_nxt    = m0_data_o;
        m1_ready_nxt   = 1'b0;
        m1_valid_nxt   = 1'b0;
        m1_error_nxt   = 1'b0;
        m1_data_nxt    = m1_data_o;
`ifdef W0RM_MEMARB_TIMEOUT_EN
        cnt_nxt        = cnt;
`endif
        case (state)
            IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    // pick=1 selects m1; on a tie the master not granted last time wins
                    pick           = (m0_valid_i && m1_valid_i) ? ~last_grant : m1_valid_i;
                    owner_nxt      = pick;
                    last_grant_nxt = pick;
                    s_valid_nxt    = 1'b1;
                    s_read_nxt     = pick ? m1_read_i  : m0_read_i;
                    s_write_nxt    = pick ? m1_write_i : m0_write_i;
                    s_addr_nxt     = pick ? m1_addr_i  : m0_addr_i;
                    s_data_nxt     = pick ? m1_data_i  : m0_data_i;
                    m0_ready_nxt   = ~pick;
                    m1_ready_nxt   = pick;
                    state_nxt      = WAIT;
`ifdef W0RM_MEMARB_TIMEOUT_EN
                    cnt_nxt        = '0;
`endif
                end
            end
            WAIT: begin
                if (s_valid_i) begin
                    rsp_fire = 1'b1;
`ifdef W0RM_MEMARB_TIMEOUT_EN
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
`endif
                end
                if (rsp_fire) begin
                    state_nxt = IDLE;
                    if (owner) begin
                        m1_valid_nxt = 1'b1;
                        m1_error_nxt = rsp_err;
                        m1_data_nxt  = rsp_err ? '0 : s_data_i;
                    end else begin
                        m0_valid_nxt = 1'b1;
                        m0_error_nxt = rsp_err;
                        m0_data_nxt  = rsp_err ? '0 : s_data_i;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_w0rm_mem_port_arbiter.sv
// Directed self-checking bench for w0rm_mem_port_arbiter; timeout scenarios are selected
// by W0RM_MEMARB_TIMEOUT_EN, otherwise the bench checks that WAIT persists.
module tb_w0rm_mem_port_arbiter;

    logic        mem_clk = 1'b0;
    logic        mem_reset_n = 1'b0;
    logic        m0_valid_i = 1'b0, m0_read_i = 1'b0, m0_write_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m0_data_i = '0;
    logic        m0_ready_o, m0_valid_o, m0_error_o;
    logic [31:0] m0_data_o;
    logic        m1_valid_i = 1'b0, m1_read_i = 1'b0, m1_write_i = 1'b0;
    logic [31:0] m1_addr_i = '0, m1_data_i = '0;
    logic        m1_ready_o, m1_valid_o, m1_error_o;
    logic [31:0] m1_data_o;
    logic        s_valid_o, s_read_o, s_write_o;
    logic [31:0] s_addr_o, s_data_o;
    logic        s_valid_i = 1'b0;
    logic [31:0] s_data_i = '0;

    int errors = 0;
    int checks = 0;
    logic [31:0] mem_word = '0;

    w0rm_mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .mem_clk(mem_clk), .mem_reset_n(mem_reset_n),
        .m0_valid_i(m0_valid_i), .m0_read_i(m0_read_i), .m0_write_i(m0_write_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_ready_o(m0_ready_o),
        .m0_valid_o(m0_valid_o), .m0_data_o(m0_data_o), .m0_error_o(m0_error_o),
        .m1_valid_i(m1_valid_i), .m1_read_i(m1_read_i), .m1_write_i(m1_write_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_ready_o(m1_ready_o),
        .m1_valid_o(m1_valid_o), .m1_data_o(m1_data_o), .m1_error_o(m1_error_o),
        .s_valid_o(s_valid_o), .s_read_o(s_read_o), .s_write_o(s_write_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic test_reset();
        mem_reset_n = 1'b0;
        repeat (2) @(negedge mem_clk);
        checks++; if ({s_valid_o, s_read_o, s_write_o} !== 3'b000) begin errors++; $display("[TB] FAIL reset_s_ctrl: got %b want 000", {s_valid_o, s_read_o, s_write_o}); end
        checks++; if ({m0_ready_o, m0_valid_o, m0_error_o, m1_ready_o, m1_valid_o, m1_error_o} !== 6'b0) begin errors++; $display("[TB] FAIL reset_m_ctrl: got %b want 000000", {m0_ready_o, m0_valid_o, m0_error_o, m1_ready_o, m1_valid_o, m1_error_o}); end
        checks++; if ({s_addr_o, s_data_o, m0_data_o, m1_data_o} !== 128'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", {s_addr_o, s_data_o, m0_data_o, m1_data_o}); end
        mem_reset_n = 1'b1;
    endtask

    task automatic test_basic_read();
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h4000_0004;
        @(negedge mem_clk);
        checks++; if ({s_valid_o, s_read_o, s_write_o} !== 3'b110) begin errors++; $display("[TB] FAIL basic_s_ctrl: got %b want 110", {s_valid_o, s_read_o, s_write_o}); end
        checks++; if (s_addr_o !== 32'h4000_0004) begin errors++; $display("[TB] FAIL basic_s_addr: got %h want 40000004", s_addr_o); end
        checks++; if ({m0_ready_o, m1_ready_o} !== 2'b10) begin errors++; $display("[TB] FAIL basic_ready: got %b want 10", {m0_ready_o, m1_ready_o}); end
        m0_valid_i = 1'b0; m0_read_i = 1'b0;
        @(negedge mem_clk);
        checks++; if ({s_valid_o, s_read_o, m0_ready_o, m0_valid_o} !== 4'b0000) begin errors++; $display("[TB] FAIL basic_pulse_end: got %b want 0000", {s_valid_o, s_read_o, m0_ready_o, m0_valid_o}); end
        s_valid_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
        @(negedge mem_clk);
        s_valid_i = 1'b0;
        checks++; if ({m0_valid_o, m0_error_o, m1_valid_o} !== 3'b100) begin errors++; $display("[TB] FAIL basic_rsp_ctrl: got %b want 100", {m0_valid_o, m0_error_o, m1_valid_o}); end
        checks++; if (m0_data_o !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL basic_rsp_data: got %h want deadbeef", m0_data_o); end
        @(negedge mem_clk);
        checks++; if (m0_valid_o !== 1'b0 || m0_data_o !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL basic_rsp_hold: got valid=%b data=%h want 0/deadbeef", m0_valid_o, m0_data_o); end
    endtask

    task automatic test_round_robin();
        logic exp_m1;
        mem_reset_n = 1'b0;
        @(negedge mem_clk);
        mem_reset_n = 1'b1;
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h4000_0100;
        m1_valid_i = 1'b1; m1_read_i = 1'b1; m1_addr_i = 32'h4000_0200;
        for (int i = 0; i < 4; i++) begin
            exp_m1 = (i % 2 == 1);
            @(negedge mem_clk);
            checks++; if ({m0_ready_o, m1_ready_o} !== {~exp_m1, exp_m1}) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b want %b", i, {m0_ready_o, m1_ready_o}, {~exp_m1, exp_m1}); end
            checks++; if (s_addr_o !== (exp_m1 ? 32'h4000_0200 : 32'h4000_0100)) begin errors++; $display("[TB] FAIL rr_addr%0d: got %h", i, s_addr_o); end
            @(negedge mem_clk);
            checks++; if ({m0_ready_o, m1_ready_o} !== 2'b00) begin errors++; $display("[TB] FAIL rr_no_ready%0d: got %b want 00", i, {m0_ready_o, m1_ready_o}); end
            s_valid_i = 1'b1; s_data_i = 32'h0000_00A0 + 32'(i);
            @(negedge mem_clk);
            s_valid_i = 1'b0;
            checks++; if ({m0_valid_o, m1_valid_o} !== {~exp_m1, exp_m1}) begin errors++; $display("[TB] FAIL rr_rsp%0d: got %b want %b", i, {m0_valid_o, m1_valid_o}, {~exp_m1, exp_m1}); end
            checks++; if ((exp_m1 ? m1_data_o : m0_data_o) !== 32'h0000_00A0 + 32'(i)) begin errors++; $display("[TB] FAIL rr_data%0d: got %h want %h", i, exp_m1 ? m1_data_o : m0_data_o, 32'h0000_00A0 + 32'(i)); end
        end
        m0_valid_i = 1'b0; m0_read_i = 1'b0;
        m1_valid_i = 1'b0; m1_read_i = 1'b0;
    endtask

    task automatic test_write_read();
        m1_valid_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h4000_0010; m1_data_i = 32'h1234_5678;
        @(negedge mem_clk);
        checks++; if ({m1_ready_o, s_valid_o, s_write_o, s_read_o} !== 4'b1110) begin errors++; $display("[TB] FAIL wr_req_ctrl: got %b want 1110", {m1_ready_o, s_valid_o, s_write_o, s_read_o}); end
        checks++; if (s_addr_o !== 32'h4000_0010 || s_data_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL wr_req_payload: got %h/%h want 40000010/12345678", s_addr_o, s_data_o); end
        if (s_write_o) mem_word = s_data_o;
        m1_valid_i = 1'b0; m1_write_i = 1'b0;
        @(negedge mem_clk);
        s_valid_i = 1'b1; s_data_i = 32'h0;
        @(negedge mem_clk);
        s_valid_i = 1'b0;
        checks++; if ({m1_valid_o, m1_error_o, m0_valid_o} !== 3'b100) begin errors++; $display("[TB] FAIL wr_ack: got %b want 100", {m1_valid_o, m1_error_o, m0_valid_o}); end
        m1_valid_i = 1'b1; m1_read_i = 1'b1;
        @(negedge mem_clk);
        checks++; if ({m1_ready_o, s_read_o, s_write_o} !== 3'b110) begin errors++; $display("[TB] FAIL rd_req_ctrl: got %b want 110", {m1_ready_o, s_read_o, s_write_o}); end
        m1_valid_i = 1'b0; m1_read_i = 1'b0;
        @(negedge mem_clk);
        s_valid_i = 1'b1; s_data_i = mem_word;
        @(negedge mem_clk);
        s_valid_i = 1'b0;
        checks++; if (m1_valid_o !== 1'b1 || m1_data_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL rd_data: got valid=%b data=%h want 1/12345678", m1_valid_o, m1_data_o); end
    endtask

`ifdef W0RM_MEMARB_TIMEOUT_EN
    task automatic test_timeout();
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h8000_0000;
        @(negedge mem_clk);
        checks++; if ({s_valid_o, m0_ready_o} !== 2'b11) begin errors++; $display("[TB] FAIL to_req: got %b want 11", {s_valid_o, m0_ready_o}); end
        m0_valid_i = 1'b0; m0_read_i = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            if (k == 16) begin
                m1_valid_i = 1'b1; m1_read_i = 1'b1; m1_addr_i = 32'h4000_0030;
            end
            @(negedge mem_clk);
            checks++; if (m0_valid_o !== 1'b0 || m1_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL to_early%0d: got valid=%b m1_ready=%b want 0/0", k, m0_valid_o, m1_ready_o); end
        end
        @(negedge mem_clk);
        checks++; if ({m0_valid_o, m0_error_o, m1_ready_o} !== 3'b110) begin errors++; $display("[TB] FAIL to_rsp: got %b want 110", {m0_valid_o, m0_error_o, m1_ready_o}); end
        checks++; if (m0_data_o !== 32'h0) begin errors++; $display("[TB] FAIL to_data: got %h want 0", m0_data_o); end
        @(negedge mem_clk);
        checks++; if ({m1_ready_o, m0_error_o} !== 2'b10 || s_addr_o !== 32'h4000_0030) begin errors++; $display("[TB] FAIL to_next_grant: got ready=%b err=%b addr=%h", m1_ready_o, m0_error_o, s_addr_o); end
        m1_valid_i = 1'b0; m1_read_i = 1'b0;
        @(negedge mem_clk);
        s_valid_i = 1'b1; s_data_i = 32'h5555_AAAA;
        @(negedge mem_clk);
        s_valid_i = 1'b0;
        checks++; if ({m1_valid_o, m1_error_o} !== 2'b10 || m1_data_o !== 32'h5555_AAAA) begin errors++; $display("[TB] FAIL to_next_rsp: got %b data=%h", {m1_valid_o, m1_error_o}, m1_data_o); end
    endtask

    task automatic test_late_response();
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h8000_0004;
        @(negedge mem_clk);
        m0_valid_i = 1'b0; m0_read_i = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            @(negedge mem_clk);
        end
        checks++; if (m0_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL late_early: got %b want 0", m0_valid_o); end
        s_valid_i = 1'b1; s_data_i = 32'hCAFE_F00D;
        @(negedge mem_clk);
        s_valid_i = 1'b0;
        checks++; if ({m0_valid_o, m0_error_o} !== 2'b10 || m0_data_o !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL late_rsp: got %b data=%h want 10/cafef00d", {m0_valid_o, m0_error_o}, m0_data_o); end
    endtask
`else
    task automatic test_no_timeout();
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h8000_0000;
        @(negedge mem_clk);
        m0_valid_i = 1'b0; m0_read_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge mem_clk);
            checks++; if (m0_valid_o !== 1'b0 || m0_error_o !== 1'b0) begin errors++; $display("[TB] FAIL nto_wait%0d: got %b want 00", k, {m0_valid_o, m0_error_o}); end
        end
        s_valid_i = 1'b1; s_data_i = 32'hCAFE_F00D;
        @(negedge mem_clk);
        s_valid_i = 1'b0;
        checks++; if ({m0_valid_o, m0_error_o} !== 2'b10 || m0_data_o !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL nto_rsp: got %b data=%h want 10/cafef00d", {m0_valid_o, m0_error_o}, m0_data_o); end
    endtask
`endif

    task automatic test_stray_response();
        @(negedge mem_clk);
        s_valid_i = 1'b1; s_data_i = 32'h1111_1111;
        @(negedge mem_clk);
        s_valid_i = 1'b0;
        checks++; if ({m0_valid_o, m1_valid_o} !== 2'b00) begin errors++; $display("[TB] FAIL stray_valid: got %b want 00", {m0_valid_o, m1_valid_o}); end
        checks++; if (m0_data_o === 32'h1111_1111 || m1_data_o === 32'h1111_1111) begin errors++; $display("[TB] FAIL stray_data: got %h/%h want neither 11111111", m0_data_o, m1_data_o); end
    endtask

    task automatic test_reset_mid_wait();
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h4000_0008;
        @(negedge mem_clk);
        checks++; if (m0_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rmw_ready: got %b want 1", m0_ready_o); end
        m0_valid_i = 1'b0; m0_read_i = 1'b0;
        @(negedge mem_clk);
        mem_reset_n = 1'b0;
        @(negedge mem_clk);
        mem_reset_n = 1'b1;
        s_valid_i = 1'b1; s_data_i = 32'hBAD0_BAD0;
        checks++; if ({s_addr_o, m0_data_o, m1_data_o} !== 96'h0 || {s_valid_o, m0_ready_o, m0_valid_o, m1_valid_o} !== 4'b0) begin errors++; $display("[TB] FAIL rmw_cleared: got addr=%h d0=%h d1=%h", s_addr_o, m0_data_o, m1_data_o); end
        @(negedge mem_clk);
        s_valid_i = 1'b0;
        checks++; if ({m0_valid_o, m1_valid_o, m0_error_o} !== 3'b000 || m0_data_o !== 32'h0) begin errors++; $display("[TB] FAIL rmw_no_rsp: got %b data=%h want 000/0", {m0_valid_o, m1_valid_o, m0_error_o}, m0_data_o); end
        m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h4000_0020;
        @(negedge mem_clk);
        checks++; if ({m0_ready_o, s_valid_o} !== 2'b11 || s_addr_o !== 32'h4000_0020) begin errors++; $display("[TB] FAIL rmw_regrant: got %b addr=%h want 11/40000020", {m0_ready_o, s_valid_o}, s_addr_o); end
        m0_valid_i = 1'b0; m0_read_i = 1'b0;
        @(negedge mem_clk);
        s_valid_i = 1'b1; s_data_i = 32'h0BAD_CAFE;
        @(negedge mem_clk);
        s_valid_i = 1'b0;
        checks++; if (m0_valid_o !== 1'b1 || m0_data_o !== 32'h0BAD_CAFE) begin errors++; $display("[TB] FAIL rmw_rsp: got valid=%b data=%h want 1/0badcafe", m0_valid_o, m0_data_o); end
    endtask

    initial begin
        $display("[TB] starting w0rm_mem_port_arbiter bench");
        test_reset();
        test_basic_read();
        test_round_robin();
        test_write_read();
`ifdef W0RM_MEMARB_TIMEOUT_EN
        test_timeout();
        test_late_response();
`else
        test_no_timeout();
`endif
        test_stray_response();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/w0rm_mem_port_arbiter.md
Name: w0rm_mem_port_arbiter

Overview:
- Two-master to one-slave arbiter that sits directly upstream of a single-port memory block.
- Masters are instruction fetch (m0) and load/store (m1). The arbiter grants one master at a time, round-robin, and allows one outstanding transaction.
- It drives a one-cycle request pulse to the memory port and routes the memory's registered response back to the granted master.
- Unmapped addresses, which the memory never answers, are terminated by a timeout with an error response.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, data width on all ports.
- TIMEOUT, 16, number of WAIT cycles with no response before an error response; minimum 2.

Ports:
- mem_clk  in  1  clock; all logic on the rising edge.
- mem_reset_n  in  1  reset, synchronous, active-low.
- m0_valid_i / m1_valid_i  in  1  master request; held until the matching ready pulse.
- m0_read_i / m1_read_i  in  1  read request.
- m0_write_i / m1_write_i  in  1  write request.
- m0_addr_i / m1_addr_i  in  ADDR_WIDTH  request address.
- m0_data_i / m1_data_i  in  DATA_WIDTH  write data.
- m0_ready_o / m1_ready_o  out  1  one-cycle pulse: request accepted.
- m0_valid_o / m1_valid_o  out  1  one-cycle pulse: response present.
- m0_data_o / m1_data_o  out  DATA_WIDTH  read data; 0 on error.
- m0_error_o / m1_error_o  out  1  qualifies valid_o: timeout occurred.
- s_valid_o, s_read_o, s_write_o  out  1  request to the memory.
- s_addr_o  out  ADDR_WIDTH  request address to the memory.
- s_data_o  out  DATA_WIDTH  write data to the memory.
- s_valid_i  in  1  memory response valid.
- s_data_i  in  DATA_WIDTH  memory read data.

Behaviour:
- All outputs are registered.
- Reset (mem_reset_n=0 at an edge):
  - state=IDLE; all *_valid_o, *_ready_o, *_error_o, s_read_o, s_write_o = 0; all data/addr outputs = 0; timeout counter = 0.
  - last_grant=1, so m0 wins the first tie.
  - Reset asserted mid-transaction abandons it; no response is ever delivered for it.
- States: IDLE, WAIT.
- IDLE, no request: nothing happens.
- IDLE, request present at edge E1:
  - Grant the master with valid_i=1. If both request, grant the one that is not last_grant; update last_grant.
  - Latch read/write/addr/data onto s_* outputs; s_valid_o=1 for exactly one cycle.
  - mX_ready_o=1 for exactly one cycle, coincident with s_valid_o.
  - Clear the counter; go to WAIT.
  - A request with read=write=0 is forwarded unchanged; the memory will not respond, so it times out.
- WAIT:
  - s_valid_o, s_read_o, s_write_o = 0 from E2 on. Counter increments each cycle.
  - s_valid_i=1 at an edge: mX_valid_o=1, mX_data_o=s_data_i (write ack returns whatever s_data_i holds), mX_error_o=0; go to IDLE.
  - Counter reaches TIMEOUT-1 with s_valid_i=0: mX_valid_o=1, mX_error_o=1, mX_data_o=0; go to IDLE.
  - s_valid_i in the same cycle as expiry: the response wins, error=0.
  - Requests are ignored in WAIT. Masters keep valid_i high until they see ready, and drop it at the edge after ready, or present the next request.
- s_valid_i while in IDLE is stray and ignored; no master valid_o.
- Response valid/error pulses last one cycle. Data outputs hold their value until the next response.
- Timing against a one-cycle-registered memory:
  - request sampled at E1 -> s_valid_o high E1..E2 -> s_valid_i high E2..E3 -> mX_valid_o high E3..E4.
  - IDLE again after E3; next grant at E4.
  - Peak throughput: one transaction per 3 cycles.

Optional Feature:
- Macro: W0RM_MEMARB_TIMEOUT_EN.
- Defined: timeout counter present, behaviour as above.
- Undefined: no counter; WAIT persists until s_valid_i or reset. mX_error_o are tied 0 and TIMEOUT is unused.

Test Plan:
- Reset with all inputs 0, then m0 read 0x4000_0004 with memory returning 0xDEADBEEF -> s_valid_o 1 cycle, s_addr_o=0x4000_0004, m0_ready_o same cycle, m0_valid_o=1/data=0xDEADBEEF/error=0 two cycles later.
- m0 and m1 request at the same edge, held continuously for 4 transactions -> grants m0,m1,m0,m1; each master sees exactly one ready per grant.
- m1 write 0x4000_0010 data 0x12345678, then m1 read of the same address -> write ack error=0, read returns 0x12345678.
- m0 read 0x8000_0000 (unmapped), TIMEOUT=16, macro defined -> m0_valid_o=1, error=1, data=0, exactly 16 cycles after s_valid_o; arbiter accepts m1 on the next cycle.
- s_valid_i injected at counter=TIMEOUT-1 -> error=0 with s_data_i returned. Stray s_valid_i in IDLE -> no mX_valid_o.
- mem_reset_n=0 for one edge while in WAIT, followed by a late s_valid_i -> all outputs 0, no response; the next m0 request is granted normally.
